demux_striping_n: RTL and testbench
===================================

// Module: demux_striping_n
// PURPOSE
//  Parametrised byte-striping demux. Splits one WIDTH-bit valid/ready stream
//  round-robin across NUM_LANES output lanes: word i goes to lane (i mod NUM_LANES).
//  Each lane has its own FIFO, so one lane can stall without losing data.
//  Sits between the serial/packet front end and the per-lane physical paths.
//  Replaces the fixed 2-lane, dual-clock striper; runs on a single clock.
// PARAMETERS
//  WIDTH          32  data word width, bits
//  NUM_LANES      4   number of output lanes; >=2
//  FIFO_DEPTH     4   words per lane FIFO; power of two, >=2
//  ALIGN_ON_IDLE  1   1: lane pointer returns to lane 0 after any idle cycle
// PORTS
//  clk_f      in   1                single clock, all logic on rising edge
//  reset      in   1                asynchronous, active-high
//  data_in    in   WIDTH            input word
//  valid_in   in   1                data_in valid
//  ready_out  out  1                word accepted when valid_in & ready_out
//  data_out   out  NUM_LANES*WIDTH  lane k head word at [k*WIDTH +: WIDTH]
//  valid_out  out  NUM_LANES        lane k FIFO non-empty
//  ready_in   in   NUM_LANES        lane k consumer pops on valid_out[k] & ready_in[k]
//  lane_ptr   out  clog2(NUM_LANES) lane that receives the next accepted word
//  word_cnt   out  16               accepted-word count, wraps 0xFFFF->0
// BEHAVIOUR
//  - Reset (async assert, sync release): ptr=0, all FIFOs empty, valid_out=0,
//    data_out=0, word_cnt=0. ready_out goes to 1 the first cycle after release.
//  - ready_out = ~full[lane_ptr]. It is purely a function of registered state:
//    no combinational path from ready_in to ready_out.
//  - Accept (valid_in & ready_out) at edge t:
//    - word is written into FIFO[lane_ptr];
//    - lane_ptr <= (lane_ptr==NUM_LANES-1) ? 0 : lane_ptr+1;
//    - word_cnt increments.
//  - Latency: a word accepted into an empty lane at edge t shows on data_out
//    and valid_out[k] from edge t (visible the following cycle). One-cycle latency.
//  - Stall (valid_in & ~ready_out): lane_ptr holds. The source must keep
//    data_in stable. The stall is not an idle cycle.
//  - Idle (valid_in=0):
//    - ALIGN_ON_IDLE=1: lane_ptr <= 0;
//    - ALIGN_ON_IDLE=0: lane_ptr holds.
//  - Lane FIFO: first-word-fall-through, registered head.
//    - Push and pop in the same cycle: count unchanged; head advances.
//    - Full lane with a pop in the same cycle: still not ready that cycle
//      (full is checked before the pop). It accepts the next cycle.
//    - Pop on an empty lane: ignored. The pointer does not move and data_out holds.
//  - data_out[k] holds its last value when empty. Only valid_out qualifies it.
//  - Pointers wrap mod FIFO_DEPTH. Count range is 0..FIFO_DEPTH.
//  - Reset mid-stream: all in-flight words are discarded and no valid_out
//    glitches high. After release, the first word goes to lane 0.
// TESTING  (WIDTH=32, NUM_LANES=4, FIFO_DEPTH=4, ALIGN_ON_IDLE=1 unless noted)
//  1 Reset:
//    - assert reset mid-cycle -> valid_out=0 immediately;
//    - after release: lane_ptr=0, word_cnt=0, ready_out=1.
//  2 Striping:
//    - stimulus: 8 back-to-back words 0xEEEEEEEE..0xEEEEEEF5, ready_in=4'hF;
//    - lane0 -> EE,F2; lane1 -> EF,F3; lane2 -> F0,F4; lane3 -> F1,F5
//      (low bytes shown), each one cycle after accept;
//    - word_cnt=8.
//  3 Backpressure:
//    - stimulus: ready_in[1]=0, stream 20 words;
//    - after lane1 holds 4 words, ready_out=0 when lane_ptr=1; lane_ptr stays 1;
//    - raise ready_in[1] -> stream resumes, no word lost or duplicated.
//  4 Idle realign:
//    - stimulus: 3 words, then valid_in=0 for 1 cycle, then word 0xA5A5A5A5;
//    - 0xA5A5A5A5 appears on lane0;
//    - with ALIGN_ON_IDLE=0 it appears on lane3 instead.
//  5 Full + simultaneous pop:
//    - stimulus: lane0 full, pop and offer a word in the same cycle;
//    - ready_out=0 that cycle, word accepted the next cycle;
//    - lane0 count stays 4.
//  6 Reset mid-stream:
//    - stimulus: assert reset with 2 words in each FIFO;
//    - all valid_out=0;
//    - next word after release lands in lane0, word_cnt=1.

Source files
------------

// File: rtl/demux_striping_n_if.sv
// Stream bundle for demux_striping_n: one valid/ready word stream in,
// NUM_LANES lane streams out, plus lane pointer and accepted-word counter.
interface demux_striping_n_if #(
  parameter int WIDTH     = 32,
  parameter int NUM_LANES = 4
);
  localparam int LW = $clog2(NUM_LANES);

  logic [WIDTH-1:0]           data_in;
  logic                       valid_in;
  logic                       ready_out;
  logic [NUM_LANES*WIDTH-1:0] data_out;
  logic [NUM_LANES-1:0]       valid_out;
  logic [NUM_LANES-1:0]       ready_in;
  logic [LW-1:0]              lane_ptr;
  logic [15:0]                word_cnt;

  modport master (
    output data_in, valid_in, ready_in,
    input  ready_out, data_out, valid_out, lane_ptr, word_cnt
  );

  modport slave (
    input  data_in, valid_in, ready_in,
    output ready_out, data_out, valid_out, lane_ptr, word_cnt
  );
endinterface

// File: rtl/demux_striping_n.sv
// Round-robin word striper: each accepted word goes to lane lane_ptr, and every
// lane has its own first-word-fall-through FIFO with a registered head word.
module demux_striping_n #(
  parameter int WIDTH         = 32,
  parameter int NUM_LANES     = 4,
  parameter int FIFO_DEPTH    = 4,
  parameter bit ALIGN_ON_IDLE = 1'b1
) (
  input logic                clk_f,
  input logic                reset,
  demux_striping_n_if.slave  bus
);
  localparam int LW = $clog2(NUM_LANES);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [LW-1:0] LAST_LANE = LW'(NUM_LANES - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);

  logic [LW-1:0]    lane_ptr_q, lane_ptr_d;
  logic [15:0]      word_cnt_q, word_cnt_d;
  logic             rdy_en_q, rdy_en_d;
  logic [PW-1:0]    wr_ptr_q [NUM_LANES];
  logic [PW-1:0]    wr_ptr_d [NUM_LANES];
  logic [PW-1:0]    rd_ptr_q [NUM_LANES];
  logic [PW-1:0]    rd_ptr_d [NUM_LANES];
  logic [CW-1:0]    cnt_q    [NUM_LANES];
  logic [CW-1:0]    cnt_d    [NUM_LANES];
  logic [WIDTH-1:0] head_q   [NUM_LANES];
  logic [WIDTH-1:0] head_d   [NUM_LANES];
  logic [WIDTH-1:0] mem_q    [NUM_LANES][FIFO_DEPTH];
  logic [WIDTH-1:0] mem_d    [NUM_LANES][FIFO_DEPTH];

  logic                       accept;
  logic [NUM_LANES-1:0]       full;
  logic [NUM_LANES-1:0]       push;
  logic [NUM_LANES-1:0]       pop;
  logic [NUM_LANES-1:0]       valid_out_w;
  logic [NUM_LANES*WIDTH-1:0] data_out_w;

  // Fullness is judged on registered counts only, so a same-cycle pop never
  // opens ready_out; that keeps ready_in off any path into ready_out.
  always_comb begin
    for (int k = 0; k < NUM_LANES; k++) begin
      full[k] = (cnt_q[k] == FULL_CNT);
    end
  end

  assign bus.ready_out = rdy_en_q & ~full[lane_ptr_q];
  assign accept        = bus.valid_in & bus.ready_out;

  always_comb begin
    lane_ptr_d = lane_ptr_q;
    word_cnt_d = word_cnt_q;
    rdy_en_d   = 1'b1;
    if (accept) begin
      lane_ptr_d = (lane_ptr_q == LAST_LANE) ? '0 : lane_ptr_q + LW'(1);
      word_cnt_d = word_cnt_q + 16'd1;
    end else if (!bus.valid_in && ALIGN_ON_IDLE) begin
      lane_ptr_d = '0;
    end
  end

  // Head is re-read from the post-write memory image, so a word pushed into an
  // empty (or emptying) lane becomes the head on the same edge.
  always_comb begin
    mem_d = mem_q;
    for (int k = 0; k < NUM_LANES; k++) begin
      push[k]     = accept && (lane_ptr_q == LW'(k));
      pop[k]      = bus.ready_in[k] && (cnt_q[k] != '0);
      wr_ptr_d[k] = wr_ptr_q[k] + PW'(push[k]);
      rd_ptr_d[k] = rd_ptr_q[k] + PW'(pop[k]);
      cnt_d[k]    = cnt_q[k] + CW'(push[k]) - CW'(pop[k]);
      head_d[k]   = head_q[k];
      if (push[k]) begin
        mem_d[k][wr_ptr_q[k]] = bus.data_in;
      end
      if (cnt_d[k] != '0) begin
        head_d[k] = mem_d[k][rd_ptr_d[k]];
      end
    end
  end

  always_ff @(posedge clk_f or posedge reset) begin
    if (reset) begin
      lane_ptr_q <= '0;
      word_cnt_q <= '0;
      rdy_en_q   <= 1'b0;
      for (int k = 0; k < NUM_LANES; k++) begin
        wr_ptr_q[k] <= '0;
        rd_ptr_q[k] <= '0;
        cnt_q[k]    <= '0;
        head_q[k]   <= '0;
      end
    end else begin
      lane_ptr_q <= lane_ptr_d;
      word_cnt_q <= word_cnt_d;
      rdy_en_q   <= rdy_en_d;
      for (int k = 0; k < NUM_LANES; k++) begin
        wr_ptr_q[k] <= wr_ptr_d[k];
        rd_ptr_q[k] <= rd_ptr_d[k];
        cnt_q[k]    <= cnt_d[k];
        head_q[k]   <= head_d[k];
      end
    end
  end

  always_ff @(posedge clk_f) begin
    mem_q <= mem_d;
  end

  always_comb begin
    valid_out_w = '0;
    data_out_w  = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      valid_out_w[k]                = (cnt_q[k] != '0);
      data_out_w[k*WIDTH +: WIDTH] = head_q[k];
    end
  end

  assign bus.valid_out = valid_out_w;
  assign bus.data_out  = data_out_w;
  assign bus.lane_ptr  = lane_ptr_q;
  assign bus.word_cnt  = word_cnt_q;

endmodule

// File: tb/tb_demux_striping_n.sv
// Directed bench for demux_striping_n: main DUT with idle realign, plus a
// second DUT without realign sharing the same input stimulus.
module tb_demux_striping_n;
  logic clk_f;
  logic reset;
  int   checks;
  int   failures;
  bit   rec;
  logic [31:0] popped[$];

  demux_striping_n_if #(.WIDTH(32), .NUM_LANES(4)) bus ();
  demux_striping_n_if #(.WIDTH(32), .NUM_LANES(4)) bus2 ();

  demux_striping_n #(.WIDTH(32), .NUM_LANES(4), .FIFO_DEPTH(4), .ALIGN_ON_IDLE(1'b1))
    dut (.clk_f(clk_f), .reset(reset), .bus(bus));
  demux_striping_n #(.WIDTH(32), .NUM_LANES(4), .FIFO_DEPTH(4), .ALIGN_ON_IDLE(1'b0))
    dut2 (.clk_f(clk_f), .reset(reset), .bus(bus2));

  assign bus2.data_in  = bus.data_in;
  assign bus2.valid_in = bus.valid_in;
  assign bus2.ready_in = bus.ready_in;

  initial clk_f = 1'b0;
  always #5 clk_f = ~clk_f;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] lane1(input int k);
    return bus.data_out[k*32 +: 32];
  endfunction

  function automatic logic [31:0] lane2(input int k);
    return bus2.data_out[k*32 +: 32];
  endfunction

  task automatic step();
    if (rec && bus.valid_out[1] && bus.ready_in[1]) popped.push_back(lane1(1));
    @(posedge clk_f);
    #1;
  endtask

  task automatic send(input logic [31:0] w);
    int g;
    bus.data_in  = w;
    bus.valid_in = 1'b1;
    g = 0;
    while (!bus.ready_out && g < 40) begin
      step();
      g++;
    end
    if (g >= 40) check("send_timeout", 32'(g), 32'd39);
    step();
  endtask

  task automatic do_reset();
    bus.valid_in = 1'b0;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rec      = 1'b0;
    reset    = 1'b1;
    bus.data_in  = '0;
    bus.valid_in = 1'b0;
    bus.ready_in = 4'h0;
    step();
    step();

    // 1: reset state
    check("rst_valid_out", 32'(bus.valid_out), 32'h0);
    check("rst_ready_low", 32'(bus.ready_out), 32'h0);
    reset = 1'b0;
    step();
    check("rel_lane_ptr", 32'(bus.lane_ptr), 32'h0);
    check("rel_word_cnt", 32'(bus.word_cnt), 32'h0);
    check("rel_ready_out", 32'(bus.ready_out), 32'h1);
    check("rel_data_zero", 32'(|bus.data_out), 32'h0);

    // 2: striping 8 words back to back
    bus.ready_in = 4'hF;
    for (int i = 0; i < 8; i++) begin
      bus.data_in  = 32'hEEEEEEEE + 32'(i);
      bus.valid_in = 1'b1;
      check("stripe_ready", 32'(bus.ready_out), 32'h1);
      step();
      check($sformatf("stripe_valid_%0d", i), 32'(bus.valid_out[i % 4]), 32'h1);
      check($sformatf("stripe_data_%0d", i), lane1(i % 4), 32'hEEEEEEEE + 32'(i));
    end
    bus.valid_in = 1'b0;
    check("stripe_word_cnt", 32'(bus.word_cnt), 32'd8);

    // 4: idle realign (main DUT) vs hold (second DUT)
    do_reset();
    bus.ready_in = 4'hF;
    send(32'h00000401);
    send(32'h00000402);
    send(32'h00000403);
    bus.valid_in = 1'b0;
    step();
    check("idle_ptr_align", 32'(bus.lane_ptr), 32'h0);
    check("idle_ptr_hold", 32'(bus2.lane_ptr), 32'h3);
    bus.data_in  = 32'hA5A5A5A5;
    bus.valid_in = 1'b1;
    step();
    bus.valid_in = 1'b0;
    check("idle_a5_valid0", 32'(bus.valid_out[0]), 32'h1);
    check("idle_a5_lane0", lane1(0), 32'hA5A5A5A5);
    check("noalign_a5_valid3", 32'(bus2.valid_out[3]), 32'h1);
    check("noalign_a5_lane3", lane2(3), 32'hA5A5A5A5);

    // 3: backpressure on lane 1
    do_reset();
    popped.delete();
    rec = 1'b1;
    bus.ready_in = 4'b1101;
    for (int i = 0; i < 20; i++) begin
      if (i == 17) begin
        bus.data_in  = 32'h111;
        bus.valid_in = 1'b1;
        check("bp_ready_low", 32'(bus.ready_out), 32'h0);
        check("bp_ptr", 32'(bus.lane_ptr), 32'h1);
        check("bp_cnt", 32'(bus.word_cnt), 32'd17);
        repeat (3) step();
        check("bp_ptr_hold", 32'(bus.lane_ptr), 32'h1);
        check("bp_still_low", 32'(bus.ready_out), 32'h0);
        bus.ready_in = 4'hF;
        check("bp_pop_cycle_low", 32'(bus.ready_out), 32'h0);
        step();
        check("bp_ready_back", 32'(bus.ready_out), 32'h1);
      end
      send(32'h100 + 32'(i));
    end
    bus.valid_in = 1'b0;
    repeat (8) step();
    rec = 1'b0;
    check("bp_total_cnt", 32'(bus.word_cnt), 32'd20);
    check("bp_pop_count", 32'(popped.size()), 32'd5);
    for (int j = 0; j < 5; j++) begin
      check($sformatf("bp_pop_%0d", j),
            (j < popped.size()) ? popped[j] : 32'hDEADBEEF, 32'h101 + 32'(4 * j));
    end

    // 5: full lane 0 with simultaneous pop
    do_reset();
    bus.ready_in = 4'b1110;
    for (int i = 0; i < 16; i++) send(32'h500 + 32'(i));
    bus.data_in  = 32'h510;
    bus.valid_in = 1'b1;
    bus.ready_in = 4'b1111;
    check("full_ptr", 32'(bus.lane_ptr), 32'h0);
    check("full_ready_low", 32'(bus.ready_out), 32'h0);
    step();
    bus.ready_in = 4'b1110;
    check("full_after_pop_ready", 32'(bus.ready_out), 32'h1);
    check("full_head_after_pop", lane1(0), 32'h504);
    check("full_cnt_before", 32'(bus.word_cnt), 32'd16);
    step();
    bus.valid_in = 1'b0;
    check("full_accept_cnt", 32'(bus.word_cnt), 32'd17);
    check("full_accept_ptr", 32'(bus.lane_ptr), 32'h1);
    step();
    check("full_again", 32'(bus.ready_out), 32'h0);
    check("full_head_kept", lane1(0), 32'h504);

    // 6: reset mid-stream with two words per lane
    do_reset();
    bus.ready_in = 4'h0;
    for (int i = 0; i < 8; i++) send(32'h600 + 32'(i));
    bus.valid_in = 1'b0;
    check("mid_valid_before", 32'(bus.valid_out), 32'hF);
    check("mid_cnt_before", 32'(bus.word_cnt), 32'd8);
    #3;
    reset = 1'b1;
    #1;
    check("mid_valid_async", 32'(bus.valid_out), 32'h0);
    check("mid_data_async", 32'(|bus.data_out), 32'h0);
    step();
    check("mid_valid_hold", 32'(bus.valid_out), 32'h0);
    reset = 1'b0;
    step();
    bus.ready_in = 4'hF;
    bus.data_in  = 32'h6A6A6A6A;
    bus.valid_in = 1'b1;
    step();
    bus.valid_in = 1'b0;
    check("mid_first_valid", 32'(bus.valid_out), 32'h1);
    check("mid_first_data", lane1(0), 32'h6A6A6A6A);
    check("mid_first_cnt", 32'(bus.word_cnt), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
